cdb_request_buffer: RTL and testbench
=====================================

Name: cdb_request_buffer

Overview:
Requester-side agent for the common data bus (CDB) priority arbiter tree. It sits between one functional unit and one child port of the arbiter:
- Buffers completed results (tag, data, exception flag) in a small FIFO.
- Holds the arbiter request high while any result is pending.
- On grant, pops the head entry and broadcasts it on the CDB for exactly one cycle.

It lets a functional unit keep completing while it loses arbitration, without losing results.

Parameters:
DEPTH, 4, number of result entries; power of two, >= 2
DATA_W, 32, result data width
TAG_W, 6, ROB/physical-register tag width

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  synchronous, active-high reset
FLUSH  in  1  pipeline flush; discards all buffered results
in_valid  in  1  functional unit presents a completed result
in_ready  out  1  buffer can accept a result this cycle
in_tag  in  TAG_W  destination tag of the incoming result
in_data  in  DATA_W  incoming result value
in_exc  in  1  incoming result raised an exception
REQ  out  1  request to the arbiter child port (R input)
GNT  in  1  grant from the arbiter child port (G output)
cdb_valid  out  1  broadcast valid
cdb_tag  out  TAG_W  broadcast tag
cdb_data  out  DATA_W  broadcast data
cdb_exc  out  1  broadcast exception flag
count  out  $clog2(DEPTH+1)  number of buffered entries

Behaviour:
Reset and FLUSH:
- RESET is sampled at posedge CLK. Next cycle: count=0, REQ=0, in_ready=1, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_exc=0, read/write pointers=0.
- RESET asserted mid-operation drops all buffered entries and any pending broadcast. No partial state survives.
- FLUSH has the same effect as RESET, except it is a functional input. FLUSH beats push and grant in the same cycle: nothing is enqueued, nothing is broadcast.

Flags:
- REQ = (count != 0). Driven only from registered state, so the arbiter's combinational loop stays acyclic.
- in_ready = (count != DEPTH). No same-cycle bypass when full.

Push:
- Push occurs when in_valid && in_ready at posedge. Entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- in_valid while in_ready=0 is ignored. The functional unit must hold the result.

Pop and broadcast:
- Pop occurs when REQ && GNT at posedge. Head is read at rd_ptr; rd_ptr increments modulo DEPTH.
- On the cycle after a pop: cdb_valid=1 and cdb_tag/cdb_data/cdb_exc = popped entry. Grant-to-broadcast latency is 1 cycle.
- cdb_valid is high for exactly one cycle per pop. It is 0 in any cycle not preceded by a pop.
- cdb_tag, cdb_data and cdb_exc hold their last value when cdb_valid=0.
- GNT while REQ=0 is ignored: no pop, no broadcast, no state change.

Simultaneous events and boundaries:
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A pushed entry raises REQ the next cycle at the earliest. Minimum in_valid-to-cdb_valid latency is 2 cycles.
- Pointer wrap is modulo DEPTH. Empty/full are distinguished by count, not by pointer equality.
- Entries leave in strict FIFO order, whatever the grant pattern.
- Back-to-back grants drain one entry per cycle.

Decomposition:
Shared package cdb_pkg holds:
- TAG_W and DATA_W defaults.
- A cdb_entry_t struct {tag, data, exc}, shared with the arbiter tree top and the reservation-station wakeup logic.

One sub-module, cdb_fifo: synchronous FIFO of cdb_entry_t with push, pop, flush, count, full and empty. The top level adds the REQ/GNT handshake and the registered broadcast stage.

Test Plan:
1. RESET with 3 entries buffered -> next cycle count=0, REQ=0, cdb_valid=0, in_ready=1; later grants produce no broadcast.
2. Push tag=5 data=0xDEADBEEF exc=0 into empty buffer, GNT held high -> REQ=1 on cycle+1; cdb_valid=1, tag=5, data=0xDEADBEEF on cycle+2 only.
3. Push tags 1,2,3,4 with GNT=0 -> count=4, in_ready=0; 5th in_valid ignored; then GNT=1 for 4 cycles -> broadcasts 1,2,3,4 on consecutive cycles; REQ drops after the last pop.
4. With count=4: push tag=9 and grant in the same cycle -> rejected (in_ready=0), tag 1 broadcast, count=3. Next cycle, push and grant together -> count stays 3; ordering over a full wrap of pointers is verified.
5. FLUSH in the same cycle as GNT and in_valid, with 2 entries buffered -> no broadcast next cycle, count=0, REQ=0, and the new entry is not stored.
6. GNT pulsed while buffer empty -> no cdb_valid, count stays 0. Then randomized in_valid/GNT for 1000 cycles against a scoreboard -> order, tag/data/exc and one-cycle cdb_valid all match.

Source files
------------

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB widths and result-entry type
package cdb_pkg;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  exc;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_request_buffer_if.sv
// rtl/cdb_request_buffer_if.sv - result input, arbiter handshake and CDB broadcast bundle
interface cdb_request_buffer_if import cdb_pkg::*; #(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;
  logic              in_exc;
  logic              REQ;
  logic              GNT;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_exc;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_tag, in_data, in_exc, GNT,
    input  in_ready, REQ, cdb_valid, cdb_tag, cdb_data, cdb_exc, count
  );

  modport slave (
    input  in_valid, in_tag, in_data, in_exc, GNT,
    output in_ready, REQ, cdb_valid, cdb_tag, cdb_data, cdb_exc, count
  );

endinterface

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - synchronous FIFO of CDB result entries with flush
module cdb_fifo import cdb_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = cdb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_entry,
  output entry_t           rd_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rd_entry = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // DEPTH is a power of two, so pointer wrap is plain truncation.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_request_buffer.sv
// rtl/cdb_request_buffer.sv - buffers FU results and broadcasts one per arbiter grant
module cdb_request_buffer import cdb_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W
) (
  input logic                  CLK,
  input logic                  RESET,
  input logic                  FLUSH,
  cdb_request_buffer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              exc;
  } entry_t;

  entry_t           wr_entry, head;
  entry_t           cdb_entry_q, cdb_entry_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic             push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign wr_entry = '{tag: bus.in_tag, data: bus.in_data, exc: bus.in_exc};

  // REQ and in_ready come only from the registered count, keeping the arbiter loop acyclic.
  assign bus.REQ      = !fifo_empty;
  assign bus.in_ready = !fifo_full;
  assign bus.count    = fifo_count;
  assign push         = bus.in_valid && !fifo_full;
  assign pop          = !fifo_empty && bus.GNT;

  cdb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .flush    (FLUSH),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_entry_d = cdb_entry_q;
    if (FLUSH) begin
      cdb_entry_d = '0;
    end else if (pop) begin
      cdb_valid_d = 1'b1;
      cdb_entry_d = head;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_entry_q <= cdb_entry_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_entry_q.tag;
  assign bus.cdb_data  = cdb_entry_q.data;
  assign bus.cdb_exc   = cdb_entry_q.exc;

endmodule

// File: tb/tb_cdb_request_buffer.sv
// tb/tb_cdb_request_buffer.sv - bench for cdb_request_buffer against a queue model
module tb_cdb_request_buffer;
  import cdb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  cdb_request_buffer_if #(.TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W), .DEPTH(DEPTH)) bus ();

  cdb_request_buffer #(.DEPTH(DEPTH), .DATA_W(CDB_DATA_W), .TAG_W(CDB_TAG_W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .FLUSH (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a plain queue of pending results plus the last broadcast.
  cdb_entry_t mq[$];
  cdb_entry_t m_e = '0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      m_valid = 1'b0;
      m_e     = '0;
    end else begin
      bit pop_ok;
      bit push_ok;
      pop_ok  = (mq.size() != 0) && bus.GNT;
      push_ok = bus.in_valid && (mq.size() < DEPTH);
      if (pop_ok) begin
        m_e     = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (push_ok) mq.push_back('{tag: bus.in_tag, data: bus.in_data, exc: bus.in_exc});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("REQ", 64'(bus.REQ), 64'(mq.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
      chk("cdb_tag", 64'(bus.cdb_tag), 64'(m_e.tag));
      chk("cdb_data", 64'(bus.cdb_data), 64'(m_e.data));
      chk("cdb_exc", 64'(bus.cdb_exc), 64'(m_e.exc));
    end
  end

  task automatic step(input bit iv, input int tag, input logic [31:0] data, input bit exc,
                      input bit gnt, input bit fl = 1'b0, input bit rs = 1'b0);
    bus.in_valid = iv;
    bus.in_tag   = tag[CDB_TAG_W-1:0];
    bus.in_data  = data;
    bus.in_exc   = exc;
    bus.GNT      = gnt;
    flush        = fl;
    rst          = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp4[3];
    exp4 = '{13, 14, 15};

    step(0, 0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;

    // Reset with three entries buffered
    for (int k = 0; k < 3; k++) step(1, 7 + k, 32'h70 + k, 0, 0);
    chk("t1_count3", 64'(bus.count), 64'd3);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("t1_count0", 64'(bus.count), 64'd0);
    chk("t1_req0", 64'(bus.REQ), 64'd0);
    chk("t1_rdy1", 64'(bus.in_ready), 64'd1);
    chk("t1_valid0", 64'(bus.cdb_valid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 1);
      chk("t1_nobcast", 64'(bus.cdb_valid), 64'd0);
    end

    // Minimum latency with GNT held high
    step(1, 5, 32'hDEADBEEF, 0, 1);
    chk("t2_req", 64'(bus.REQ), 64'd1);
    chk("t2_valid_early", 64'(bus.cdb_valid), 64'd0);
    step(0, 0, 0, 0, 1);
    chk("t2_valid", 64'(bus.cdb_valid), 64'd1);
    chk("t2_tag", 64'(bus.cdb_tag), 64'd5);
    chk("t2_data", 64'(bus.cdb_data), 64'hDEADBEEF);
    step(0, 0, 0, 0, 1);
    chk("t2_one_cycle", 64'(bus.cdb_valid), 64'd0);
    chk("t2_hold_tag", 64'(bus.cdb_tag), 64'd5);

    // Fill, overflow attempt, drain
    for (int k = 1; k <= 4; k++) step(1, k, 32'h100 + k, (k == 3), 0);
    chk("t3_count4", 64'(bus.count), 64'd4);
    chk("t3_rdy0", 64'(bus.in_ready), 64'd0);
    chk("t3_model4", 64'(mq.size()), 64'd4);
    step(1, 5, 32'h105, 0, 0);
    chk("t3_ignored", 64'(bus.count), 64'd4);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 1);
      chk("t3_valid", 64'(bus.cdb_valid), 64'd1);
      chk("t3_tag", 64'(bus.cdb_tag), 64'(k));
      chk("t3_data", 64'(bus.cdb_data), 64'(32'h100 + k));
      chk("t3_exc", 64'(bus.cdb_exc), 64'(k == 3));
    end
    chk("t3_req_drop", 64'(bus.REQ), 64'd0);

    // Full push+grant, then push+grant across pointer wrap
    for (int k = 11; k <= 14; k++) step(1, k, 32'h200 + k, 0, 0);
    step(1, 9, 32'h209, 0, 1);
    chk("t4_tag11", 64'(bus.cdb_tag), 64'd11);
    chk("t4_count3", 64'(bus.count), 64'd3);
    step(1, 15, 32'h20F, 1, 1);
    chk("t4_tag12", 64'(bus.cdb_tag), 64'd12);
    chk("t4_count3b", 64'(bus.count), 64'd3);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      chk("t4_order", 64'(bus.cdb_tag), 64'(exp4[k]));
    end
    chk("t4_exc15", 64'(bus.cdb_exc), 64'd1);

    // FLUSH beats push and grant
    step(1, 21, 32'h21, 0, 0);
    step(1, 22, 32'h22, 0, 0);
    step(1, 23, 32'h23, 0, 1, 1);
    chk("t5_valid0", 64'(bus.cdb_valid), 64'd0);
    chk("t5_count0", 64'(bus.count), 64'd0);
    chk("t5_req0", 64'(bus.REQ), 64'd0);
    step(0, 0, 0, 0, 1);
    chk("t5_not_stored", 64'(bus.cdb_valid), 64'd0);

    // Grant while empty, then random traffic
    step(0, 0, 0, 0, 1);
    chk("t6_empty_gnt", 64'(bus.cdb_valid), 64'd0);
    chk("t6_count0", 64'(bus.count), 64'd0);
    for (int i = 0; i < 1000; i++)
      step(bit'($urandom_range(1)), int'($urandom_range(63)), $urandom, bit'($urandom_range(1)),
           ($urandom_range(2) != 0));
    step(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
